// File: rtl/watch_time_setter.sv
// Button-driven time-set controller: captures the running time, lets the user edit
// hours then minutes in BCD, and commits the result to the watch with a one-cycle load.
module watch_time_setter #(
  parameter bit          TWELVE_HR   = 1'b1,
  parameter logic [31:0] TIMEOUT_CYC = 32'd5000,
  parameter logic [15:0] BLINK_DIV   = 16'd250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       next,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [3:0] set_hr1,
  output logic [3:0] set_hr0,
  output logic [3:0] set_min1,
  output logic [3:0] set_min0,
  output logic       load,
  output logic       stop_req,
  output logic [1:0] field_sel,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_EDIT_HR, S_EDIT_MIN, S_COMMIT
  } state_t;

  localparam logic [3:0] RST_HR1 = TWELVE_HR ? 4'd1 : 4'd0;
  localparam logic [3:0] RST_HR0 = TWELVE_HR ? 4'd2 : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  hr1_reg, hr0_reg, min1_reg, min0_reg;
  logic [3:0]  hr1_next, hr0_next, min1_next, min0_next;
  logic        load_reg, load_next;
  logic        stop_reg, stop_next;
  logic [1:0]  field_reg, field_next;
  logic        blink_reg, blink_next;
  logic [31:0] tcnt_reg, tcnt_next;
  logic [15:0] bcnt_reg, bcnt_next;

  function automatic logic [7:0] bcd2bin(input logic [3:0] d1, input logic [3:0] d0);
    return {4'd0, d1} * 8'd10 + {4'd0, d0};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 8'd10);
    o = 4'(v - {4'd0, t} * 8'd10);
    return {t, o};
  endfunction

  logic [7:0] hr_bin, min_bin, cap_hr, hr_up, hr_dn, min_up, min_dn;
  logic       cap_hr_ok, cap_min_ok;

  assign hr_bin  = bcd2bin(hr1_reg, hr0_reg);
  assign min_bin = bcd2bin(min1_reg, min0_reg);
  assign cap_hr  = bcd2bin(cur_hr1, cur_hr0);

  // Non-BCD digits must be rejected before the binary range check means anything.
  assign cap_hr_ok  = (cur_hr1 <= 4'd9) && (cur_hr0 <= 4'd9) &&
                      (TWELVE_HR ? (cap_hr >= 8'd1 && cap_hr <= 8'd12) : (cap_hr <= 8'd23));
  assign cap_min_ok = (cur_min1 <= 4'd5) && (cur_min0 <= 4'd9);

  assign hr_up  = bin2bcd(TWELVE_HR ? ((hr_bin == 8'd12) ? 8'd1 : hr_bin + 8'd1)
                                    : ((hr_bin == 8'd23) ? 8'd0 : hr_bin + 8'd1));
  assign hr_dn  = bin2bcd(TWELVE_HR ? ((hr_bin == 8'd1) ? 8'd12 : hr_bin - 8'd1)
                                    : ((hr_bin == 8'd0) ? 8'd23 : hr_bin - 8'd1));
  assign min_up = bin2bcd((min_bin == 8'd59) ? 8'd0 : min_bin + 8'd1);
  assign min_dn = bin2bcd((min_bin == 8'd0) ? 8'd59 : min_bin - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      hr1_reg   <= RST_HR1;
      hr0_reg   <= RST_HR0;
      min1_reg  <= 4'd0;
      min0_reg  <= 4'd0;
      load_reg  <= 1'b0;
      stop_reg  <= 1'b0;
      field_reg <= 2'b00;
      blink_reg <= 1'b0;
      tcnt_reg  <= 32'd0;
      bcnt_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      hr1_reg   <= hr1_next;
      hr0_reg   <= hr0_next;
      min1_reg  <= min1_next;
      min0_reg  <= min0_next;
      load_reg  <= load_next;
      stop_reg  <= stop_next;
      field_reg <= field_next;
      blink_reg <= blink_next;
      tcnt_reg  <= tcnt_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hr1_next   = hr1_reg;
    hr0_next   = hr0_reg;
    min1_next  = min1_reg;
    min0_next  = min0_reg;
    load_next  = 1'b0;
    stop_next  = stop_reg;
    field_next = field_reg;
    blink_next = blink_reg;
    tcnt_next  = tcnt_reg;
    bcnt_next  = bcnt_reg;

    case (state_reg)
      S_IDLE: begin
        field_next = 2'b00;
        blink_next = 1'b0;
        if (mode) begin
          state_next = S_CAPTURE;
          stop_next  = 1'b1;
        end
      end
      S_CAPTURE: begin
        hr1_next   = cap_hr_ok  ? cur_hr1  : RST_HR1;
        hr0_next   = cap_hr_ok  ? cur_hr0  : RST_HR0;
        min1_next  = cap_min_ok ? cur_min1 : 4'd0;
        min0_next  = cap_min_ok ? cur_min0 : 4'd0;
        state_next = S_EDIT_HR;
        field_next = 2'b01;
        blink_next = 1'b1;
        bcnt_next  = 16'd0;
        tcnt_next  = 32'd0;
      end
      S_EDIT_HR, S_EDIT_MIN: begin
        if (bcnt_reg == BLINK_DIV - 16'd1) begin
          blink_next = ~blink_reg;
          bcnt_next  = 16'd0;
        end else begin
          bcnt_next = bcnt_reg + 16'd1;
        end
        if (mode) begin
          state_next = S_COMMIT;
          load_next  = 1'b1;
          blink_next = 1'b0;
          tcnt_next  = 32'd0;
        end else if (next) begin
          state_next = (state_reg == S_EDIT_HR) ? S_EDIT_MIN : S_EDIT_HR;
          field_next = (state_reg == S_EDIT_HR) ? 2'b10 : 2'b01;
          blink_next = 1'b1;
          bcnt_next  = 16'd0;
          tcnt_next  = 32'd0;
        end else if (inc || dec) begin
          tcnt_next = 32'd0;
          // inc and dec together cancel: no field update, only the timeout restarts.
          if (inc != dec) begin
            if (state_reg == S_EDIT_HR) begin
              {hr1_next, hr0_next} = inc ? hr_up : hr_dn;
            end else begin
              {min1_next, min0_next} = inc ? min_up : min_dn;
            end
          end
        end else if (tcnt_reg == TIMEOUT_CYC - 32'd1) begin
          state_next = S_IDLE;
          stop_next  = 1'b0;
          field_next = 2'b00;
          blink_next = 1'b0;
          tcnt_next  = 32'd0;
        end else begin
          tcnt_next = tcnt_reg + 32'd1;
        end
      end
      S_COMMIT: begin
        state_next = S_IDLE;
        stop_next  = 1'b0;
        field_next = 2'b00;
        blink_next = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        stop_next  = 1'b0;
        field_next = 2'b00;
        blink_next = 1'b0;
      end
    endcase
  end

  assign set_hr1   = hr1_reg;
  assign set_hr0   = hr0_reg;
  assign set_min1  = min1_reg;
  assign set_min0  = min0_reg;
  assign load      = load_reg;
  assign stop_req  = stop_reg;
  assign field_sel = field_reg;
  assign blink     = blink_reg;

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed bench for watch_time_setter: a 12-hour and a 24-hour instance share stimulus.
module tb_watch_time_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0, next = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [3:0] cur_hr1 = 4'd0, cur_hr0 = 4'd0, cur_min1 = 4'd0, cur_min0 = 4'd0;

  logic [3:0] a_hr1, a_hr0, a_min1, a_min0, b_hr1, b_hr0, b_min1, b_min0;
  logic       a_load, a_stop, a_blink, b_load, b_stop, b_blink;
  logic [1:0] a_field, b_field;

  int n_checks = 0;
  int n_fail   = 0;
  int a_load_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_load) a_load_cnt <= a_load_cnt + 1;

  watch_time_setter #(.TWELVE_HR(1'b1), .TIMEOUT_CYC(32'd16), .BLINK_DIV(16'd4)) u_dut12 (
    .clk(clk), .reset(reset), .mode(mode), .next(next), .inc(inc), .dec(dec),
    .cur_hr1(cur_hr1), .cur_hr0(cur_hr0), .cur_min1(cur_min1), .cur_min0(cur_min0),
    .set_hr1(a_hr1), .set_hr0(a_hr0), .set_min1(a_min1), .set_min0(a_min0),
    .load(a_load), .stop_req(a_stop), .field_sel(a_field), .blink(a_blink)
  );

  watch_time_setter #(.TWELVE_HR(1'b0), .TIMEOUT_CYC(32'd16), .BLINK_DIV(16'd4)) u_dut24 (
    .clk(clk), .reset(reset), .mode(mode), .next(next), .inc(inc), .dec(dec),
    .cur_hr1(cur_hr1), .cur_hr0(cur_hr0), .cur_min1(cur_min1), .cur_min0(cur_min0),
    .set_hr1(b_hr1), .set_hr0(b_hr0), .set_min1(b_min1), .set_min0(b_min0),
    .load(b_load), .stop_req(b_stop), .field_sel(b_field), .blink(b_blink)
  );

  function automatic logic [15:0] a_set();
    return {a_hr1, a_hr0, a_min1, a_min0};
  endfunction

  function automatic logic [15:0] b_set();
    return {b_hr1, b_hr0, b_min1, b_min0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic m, input logic nx, input logic i, input logic d);
    mode = m; next = nx; inc = i; dec = d;
    @(posedge clk);
    #1;
    mode = 1'b0; next = 1'b0; inc = 1'b0; dec = 1'b0;
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_hr1, cur_hr0, cur_min1, cur_min0} = v;
  endtask

  task automatic enter();
    drive(1, 0, 0, 0);
    tick(1);
  endtask

  initial begin
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst_set12", a_set(), 16'h1200);
    check("rst_set24", b_set(), 16'h0000);
    check("rst_outs", {a_load, a_stop, a_field, a_blink}, 5'b0);

    // T1: capture 10:47, three hour incs, one minute dec
    set_cur(16'h1047);
    drive(1, 0, 0, 0);
    check("t1_stop_n1", a_stop, 1'b1);
    check("t1_field_n1", a_field, 2'b00);
    tick(1);
    check("t1_field_n2", a_field, 2'b01);
    check("t1_capture", a_set(), 16'h1047);
    check("t1_blink_entry", a_blink, 1'b1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("t1_hr12", a_set(), 16'h1247);
    drive(0, 0, 1, 0);
    check("t1_hr_wrap", a_set(), 16'h0147);
    drive(0, 1, 0, 0);
    check("t1_field_min", a_field, 2'b10);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    check("t1_load", a_load, 1'b1);
    check("t1_set12", a_set(), 16'h0146);
    check("t1_set24", b_set(), 16'h1346);
    check("t1_stop_hold", a_stop, 1'b1);
    tick(1);
    check("t1_load_off", a_load, 1'b0);
    check("t1_stop_off", a_stop, 1'b0);
    check("t1_field_off", a_field, 2'b00);

    // T2: minute wrap both ways
    set_cur(16'h0559);
    enter();
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("t2_inc_wrap", a_set(), 16'h0500);
    drive(0, 0, 0, 1);
    check("t2_dec_wrap", a_set(), 16'h0559);
    drive(0, 0, 0, 1);
    check("t2_dec", a_set(), 16'h0558);
    drive(1, 0, 0, 0);
    tick(1);

    // T3: 24-hour wrap and invalid capture
    set_cur(16'h0000);
    enter();
    check("t3_cap12_h00", a_set(), 16'h1200);
    drive(0, 0, 0, 1);
    check("t3_dec24", b_set(), 16'h2300);
    drive(0, 0, 1, 0);
    check("t3_inc24", b_set(), 16'h0000);
    drive(1, 0, 0, 0);
    tick(1);
    set_cur(16'h2573);
    enter();
    check("t3_bad24", b_set(), 16'h0000);
    check("t3_bad12", a_set(), 16'h1200);
    drive(1, 0, 0, 0);
    tick(1);

    // T4: simultaneous inputs
    set_cur(16'h1047);
    enter();
    drive(0, 1, 1, 0);
    check("t4_next_inc_f", a_field, 2'b10);
    check("t4_next_inc_v", a_set(), 16'h1047);
    drive(0, 0, 1, 1);
    check("t4_inc_dec", a_set(), 16'h1047);
    drive(1, 0, 1, 0);
    check("t4_mode_inc_l", a_load, 1'b1);
    check("t4_mode_inc_v", a_set(), 16'h1047);
    tick(1);

    // T5: timeout with and without an intervening pulse
    snap = a_load_cnt;
    enter();
    tick(3);
    check("t5_blink_hold", a_blink, 1'b1);
    tick(1);
    check("t5_blink_tog", a_blink, 1'b0);
    tick(11);
    check("t5_edit_c15", a_field, 2'b01);
    tick(1);
    check("t5_to_field", a_field, 2'b00);
    check("t5_to_stop", a_stop, 1'b0);
    enter();
    tick(9);
    drive(0, 0, 1, 0);
    tick(10);
    check("t5_alive_c20", {a_stop, a_field}, 3'b101);
    tick(5);
    check("t5_alive_c25", a_stop, 1'b1);
    tick(1);
    check("t5_to2_stop", a_stop, 1'b0);
    check("t5_keep_set", a_set(), 16'h1147);
    check("t5_no_load", a_load_cnt, snap);

    // T6: async reset between edges while editing minutes
    enter();
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    tick(1);
    #2 reset = 1'b0;
    #1;
    check("t6_stop", a_stop, 1'b0);
    check("t6_field", a_field, 2'b00);
    check("t6_set12", a_set(), 16'h1200);
    check("t6_set24", b_set(), 16'h0000);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(3);
    check("t6_idle", {a_load, a_stop, a_field}, 4'b0);
    check("t6_no_load", a_load_cnt, snap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
